// File: rtl/rr_grant_arbiter_8.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant plus binary index.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant held; next edge with req!=0 grants first set bit from ptr
// GRANT | grant held until owner drops req (or hold limit with ARB_TIMEOUT_EN)
module rr_grant_arbiter_8 #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid,
  output logic                       timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ != 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_grant_arbiter_8: NUM_REQ must be 8 and MAX_HOLD in 2..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   sel, cand;
  logic               sel_found;
  logic               timeout_nxt;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_nxt;
`endif

  // Rotating search: ptr, ptr+1, ... wrapping through the 3-bit index.
  always_comb begin
    sel       = '0;
    cand      = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    ptr_nxt     = ptr;
    timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt = GRANT;
          gnt_nxt   = NUM_REQ'(1) << sel;
          idx_nxt   = sel;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          ptr_nxt   = gnt_idx + IDX_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          idx_nxt     = '0;
          ptr_nxt     = gnt_idx + IDX_W'(1);
          timeout_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      ptr     <= ptr_nxt;
    end
  end

  assign gnt_valid = |gnt;

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  // Without the hold limit the revoke path never fires.
  assign timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_nxt;
`endif

endmodule
